alarm_ringer: RTL and testbench

- Downstream of the alarm comparator. Consumes the raw minute-match level and the 1 Hz enable, and drives the physical buzzer.
- Adds an on/off beep cadence, a snooze countdown with a limited snooze count, stop/dismiss, and a ring timeout.
- All state is clocked on the single system clock. The 1 Hz pulse is used only as a one-cycle enable.

---
 rtl/alarm_ringer.sv | 166 ++++++++++++++++
 tb/tb_alarm_ringer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ringer.sv
// Alarm buzzer controller: beep cadence, limited snooze with countdown,
// stop/dismiss and ring timeout, downstream of the minute-match comparator.
module alarm_ringer #(
  parameter int unsigned SNOOZE_S       = 300,
  parameter int unsigned RING_TIMEOUT_S = 120,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       match,
  input  logic       alarm_on,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzz,
  output logic       ringing,
  output logic [1:0] state,
  output logic [9:0] snooze_left,
  output logic [2:0] snoozes_used
);

  localparam int unsigned CT_W   = 10;
  localparam int unsigned USED_W = 3;

  localparam logic [CT_W-1:0]   SNOOZE_LD = CT_W'(SNOOZE_S);
  localparam logic [CT_W-1:0]   RING_LAST = CT_W'(RING_TIMEOUT_S - 1);
  localparam logic [USED_W-1:0] USED_MAX  = USED_W'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RING   = 2'b01,
    ST_SNOOZE = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  state_t              r_state;
  logic                r_phase;
  logic [CT_W-1:0]     r_ring_ct;
  logic [CT_W-1:0]     r_snooze_left;
  logic [USED_W-1:0]   r_snoozes_used;
  logic                r_match_q;
  logic                r_snooze_q;
  logic                r_buzz;
  logic                r_ringing;

  state_t              w_state_nxt;
  logic                w_phase_nxt;
  logic [CT_W-1:0]     w_ring_ct_nxt;
  logic [CT_W-1:0]     w_snooze_left_nxt;
  logic [USED_W-1:0]   w_used_nxt;
  logic                w_buzz_nxt;
  logic                w_ringing_nxt;
  logic                w_match_rise;
  logic                w_snooze_rise;

  assign w_match_rise  = match & ~r_match_q;
  assign w_snooze_rise = snooze_btn & ~r_snooze_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_phase        <= 1'b0;
      r_ring_ct      <= '0;
      r_snooze_left  <= '0;
      r_snoozes_used <= '0;
      r_match_q      <= 1'b0;
      r_snooze_q     <= 1'b0;
      r_buzz         <= 1'b0;
      r_ringing      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_phase        <= w_phase_nxt;
      r_ring_ct      <= w_ring_ct_nxt;
      r_snooze_left  <= w_snooze_left_nxt;
      r_snoozes_used <= w_used_nxt;
      r_match_q      <= match;
      r_snooze_q     <= snooze_btn;
      r_buzz         <= w_buzz_nxt;
      r_ringing      <= w_ringing_nxt;
    end
  end

  // Next-state: buttons beat the tick; a refused snooze lets the tick through
  always_comb begin
    w_state_nxt       = r_state;
    w_phase_nxt       = r_phase;
    w_ring_ct_nxt     = r_ring_ct;
    w_snooze_left_nxt = r_snooze_left;
    w_used_nxt        = r_snoozes_used;
    unique case (r_state)
      ST_IDLE: begin
        if (alarm_on && w_match_rise) begin
          w_state_nxt   = ST_RING;
          w_phase_nxt   = 1'b1;
          w_ring_ct_nxt = '0;
          w_used_nxt    = '0;
        end
      end
      ST_RING: begin
        if (!alarm_on) begin
          w_state_nxt   = ST_IDLE;
          w_ring_ct_nxt = '0;
        end else if (stop_btn) begin
          w_state_nxt   = ST_DONE;
          w_ring_ct_nxt = '0;
        end else if (w_snooze_rise && (r_snoozes_used < USED_MAX)) begin
          w_state_nxt       = ST_SNOOZE;
          w_ring_ct_nxt     = '0;
          w_snooze_left_nxt = SNOOZE_LD;
          w_used_nxt        = r_snoozes_used + USED_W'(1);
        end else if (tick) begin
          w_phase_nxt = ~r_phase;
          if (r_ring_ct == RING_LAST) begin
            w_state_nxt   = ST_DONE;
            w_ring_ct_nxt = '0;
          end else begin
            w_ring_ct_nxt = r_ring_ct + CT_W'(1);
          end
        end
      end
      ST_SNOOZE: begin
        if (!alarm_on) begin
          w_state_nxt       = ST_IDLE;
          w_snooze_left_nxt = '0;
        end else if (stop_btn) begin
          w_state_nxt       = ST_DONE;
          w_snooze_left_nxt = '0;
        end else if (tick) begin
          if (r_snooze_left == CT_W'(1)) begin
            w_state_nxt       = ST_RING;
            w_phase_nxt       = 1'b1;
            w_ring_ct_nxt     = '0;
            w_snooze_left_nxt = '0;
          end else begin
            w_snooze_left_nxt = r_snooze_left - CT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (!alarm_on || !match) begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // Registered output decode from the next state
  always_comb begin
    w_buzz_nxt    = 1'b0;
    w_ringing_nxt = 1'b0;
    if (w_state_nxt == ST_RING) begin
      w_buzz_nxt = w_phase_nxt;
    end
    if ((w_state_nxt == ST_RING) || (w_state_nxt == ST_SNOOZE)) begin
      w_ringing_nxt = 1'b1;
    end
  end

  assign buzz         = r_buzz;
  assign ringing      = r_ringing;
  assign state        = r_state;
  assign snooze_left  = r_snooze_left;
  assign snoozes_used = r_snoozes_used;

endmodule

// File: tb/tb_alarm_ringer.sv
// Scoreboard bench for alarm_ringer: stimulus pushes reference-model
// expectations, a monitor pops and compares after every clock edge.
module tb_alarm_ringer;

  localparam int unsigned P_SNOOZE  = 3;
  localparam int unsigned P_TIMEOUT = 6;
  localparam int unsigned P_MAX     = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, match = 1'b0, alarm_on = 1'b0;
  logic       snooze_btn = 1'b0, stop_btn = 1'b0;
  logic       buzz, ringing;
  logic [1:0] state;
  logic [9:0] snooze_left;
  logic [2:0] snoozes_used;

  alarm_ringer #(
    .SNOOZE_S(P_SNOOZE), .RING_TIMEOUT_S(P_TIMEOUT), .MAX_SNOOZE(P_MAX)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .match(match), .alarm_on(alarm_on),
    .snooze_btn(snooze_btn), .stop_btn(stop_btn), .buzz(buzz), .ringing(ringing),
    .state(state), .snooze_left(snooze_left), .snoozes_used(snoozes_used)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       buzz;
    logic       ringing;
    logic [1:0] state;
    logic [9:0] sl;
    logic [2:0] su;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: alarm event described in seconds and counts
  int   md;          // 0 idle, 1 ringing, 2 snoozing, 3 dismissed
  bit   beep_on;
  int   secs_rung;
  int   snz_left;
  int   snz_used;
  bit   prev_match, prev_snz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    md = 0; beep_on = 0; secs_rung = 0; snz_left = 0; snz_used = 0;
    prev_match = 0; prev_snz = 0;
  endtask

  task automatic model_step(input bit t, input bit m, input bit a, input bit s, input bit p);
    bit mrise, srise;
    mrise = m && !prev_match;
    srise = s && !prev_snz;
    prev_match = m;
    prev_snz   = s;
    case (md)
      0: if (a && mrise) begin md = 1; beep_on = 1; secs_rung = 0; snz_used = 0; end
      1: begin
        if (!a) md = 0;
        else if (p) md = 3;
        else if (srise && snz_used < int'(P_MAX)) begin
          md = 2; snz_left = P_SNOOZE; snz_used++;
        end else if (t) begin
          secs_rung++;
          beep_on = !beep_on;
          if (secs_rung == int'(P_TIMEOUT)) md = 3;
        end
      end
      2: begin
        if (!a) md = 0;
        else if (p) md = 3;
        else if (t) begin
          snz_left--;
          if (snz_left == 0) begin md = 1; beep_on = 1; secs_rung = 0; end
        end
      end
      default: if (!a || !m) md = 0;
    endcase
    if (md != 2) snz_left = 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.buzz    = (md == 1) && beep_on;
    e.ringing = (md == 1) || (md == 2);
    e.state   = 2'(md);
    e.sl      = 10'(snz_left);
    e.su      = 3'(snz_used);
    return e;
  endfunction

  // Apply one cycle of inputs and queue what the DUT must show after the edge
  task automatic drive(input bit t, input bit m, input bit a, input bit s, input bit p);
    @(negedge clk);
    rst = 1'b1;
    tick = t; match = m; alarm_on = a; snooze_btn = s; stop_btn = p;
    model_step(t, m, a, s, p);
    q.push_back(model_out());
  endtask

  task automatic ticks(input int n, input bit m);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, m, 1'b1, 1'b0, 1'b0);
      drive(1'b0, m, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic press_snooze();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("buzz", 32'(buzz), 32'(e.buzz));
        chk("ringing", 32'(ringing), 32'(e.ringing));
        chk("state", 32'(state), 32'(e.state));
        chk("snooze_left", 32'(snooze_left), 32'(e.sl));
        chk("snoozes_used", 32'(snoozes_used), 32'(e.su));
      end
    end
  end

  initial begin
    bit a_r, m_r;
    model_reset();
    #1;
    chk("rst_buzz", 32'(buzz), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_snooze_left", 32'(snooze_left), 32'd0);
    chk("rst_snoozes_used", 32'(snoozes_used), 32'd0);

    // Trigger, cadence, snoozes to the limit, refused snooze, stop, drop match
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    ticks(3, 1'b1);
    for (int k = 0; k < int'(P_MAX); k++) begin
      press_snooze();
      ticks(P_SNOOZE, 1'b1);
    end
    press_snooze();
    drive(1, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 1);
    drive(0, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0);

    // Timeout with match held, then release
    drive(0, 1, 1, 0, 0);
    ticks(P_TIMEOUT + 2, 1'b1);
    drive(0, 0, 1, 0, 0);

    // Match already high when alarm enabled: no trigger
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    ticks(2, 1'b1);
    drive(0, 0, 1, 0, 0);

    // Disable during snooze
    drive(0, 1, 1, 0, 0);
    press_snooze();
    drive(1, 1, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);

    // Tick coincident with match rise, then tick with stop
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 1, 0, 1);
    drive(0, 0, 1, 0, 0);

    // Async reset in the middle of ringing
    drive(0, 1, 1, 0, 0);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 1, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_buzz", 32'(buzz), 32'd0);
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_ringing", 32'(ringing), 32'd0);
    chk("midrst_snoozes_used", 32'(snoozes_used), 32'd0);
    model_reset();
    drive(0, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0);

    // Randomized operation
    a_r = 1'b1;
    m_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (a_r) a_r = ($urandom_range(0, 199) != 0);
      else     a_r = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 24) == 0) m_r = !m_r;
      drive(bit'($urandom_range(0, 2) == 0), m_r, a_r,
            bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 79) == 0));
    end

    @(posedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
